// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and load clamp for the BCD down-counter family.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    // Any non-BCD nibble saturates to the largest legal digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit counting 9 -> 0 with a combinational borrow chain.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ld_digit,
    input  logic       bin,
    output logic [3:0] digit,
    output logic       bout
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digit <= BCD_MAX;
        end else if (ld) begin
            r_digit <= ld_digit;
        end else if (bin) begin
            r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign digit = r_digit;
    assign bout  = bin && (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter_9_to_0.sv
// Loadable, enable-gated multi-digit BCD down-counter with done/wrap/load_err pulses.
module bcd_down_counter_9_to_0
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  zero,
    output logic                  done,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int CW = 4 * DIGITS;

    state_t          r_state;
    logic            r_done;
    logic            r_wrap;
    logic            r_load_err;

    logic [CW-1:0]   w_ld_clamped;
    logic [DIGITS-1:0] w_ld_bad;
    logic [DIGITS:0] w_borrow;
    logic            w_dec;
    logic            w_zero;
    logic            w_cnt_is_one;
    logic            w_ld_zero;
    logic            w_wrap_en;

    assign w_wrap_en    = (WRAP != 0);
    assign w_zero       = (cnt == '0);
    assign w_cnt_is_one = (cnt == CW'(1));
    assign w_ld_zero    = (w_ld_clamped == '0);

    // Without wrap, a count parked at 0 must never borrow out of the top digit.
    assign w_dec = en && !load && (r_state != S_EXPIRED) && !(!w_wrap_en && w_zero);
    assign w_borrow[0] = w_dec;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_ld_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        assign w_ld_bad[i]            = (load_val[4*i +: 4] > BCD_MAX);

        bcd_digit_down u_digit (
            .clk      (clk),
            .rst      (rst),
            .ld       (load),
            .ld_digit (w_ld_clamped[4*i +: 4]),
            .bin      (w_borrow[i]),
            .digit    (cnt[4*i +: 4]),
            .bout     (w_borrow[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= w_dec && w_cnt_is_one;
            r_wrap     <= w_wrap_en && w_dec && w_borrow[DIGITS];
            r_load_err <= load && (|w_ld_bad);

            if (load) begin
                r_state <= (!w_wrap_en && w_ld_zero) ? S_EXPIRED : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_RUN: begin
                        if (!en)
                            r_state <= S_IDLE;
                        else if (!w_wrap_en && w_cnt_is_one)
                            r_state <= S_EXPIRED;
                        else
                            r_state <= S_RUN;
                    end
                    S_EXPIRED: r_state <= S_EXPIRED;
                    default:   r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign zero     = w_zero;
    assign done     = r_done;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
